// File: rtl/ni_tx_pkg.sv
// Shared definitions for the network-interface transmit path: flit type codes,
// head-flit field positions, flit width and FSM state encoding.
package ni_tx_pkg;

    localparam int FLIT_W   = 35;

    localparam int TYPE_MSB = 34;
    localparam int TYPE_LSB = 32;
    localparam int DST_MSB  = 31;
    localparam int DST_LSB  = 24;
    localparam int SRC_MSB  = 23;
    localparam int SRC_LSB  = 16;
    localparam int VCH_BIT  = 15;
    localparam int LEN_MSB  = 14;
    localparam int LEN_LSB  = 11;

    typedef enum logic [2:0] {
        FT_NONE     = 3'd0,
        FT_HEAD     = 3'd1,
        FT_BODY     = 3'd2,
        FT_TAIL     = 3'd3,
        FT_HEADTAIL = 3'd4
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic [31:0] make_head(input logic [7:0] dst,
                                              input logic [7:0] src,
                                              input logic       vch,
                                              input logic [3:0] len);
        logic [31:0] p;
        p                   = '0;
        p[DST_MSB:DST_LSB]  = dst;
        p[SRC_MSB:SRC_LSB]  = src;
        p[VCH_BIT]          = vch;
        p[LEN_MSB:LEN_LSB]  = len;
        return p;
    endfunction

endpackage

// File: rtl/ni_vcsel.sv
// Two-way round-robin virtual-channel selector: prefers the VC after the
// last one used, falls back to the last one if only it is ready.
module ni_vcsel (
    input  logic [1:0] irdy,
    input  logic       last_vc,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |irdy;
        grant = ~last_vc;
        if (!irdy[~last_vc]) grant = last_vc;
    end

endmodule

// File: rtl/ni_tx.sv
// Network-interface transmitter: turns a message request plus payload stream
// into HEAD/BODY/TAIL flits on one VC. Optional counters under NI_TX_STATS_EN.
module ni_tx
    import ni_tx_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int NVCH     = 2,
    parameter int MAXLEN   = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [7:0]        msg_dst,
    input  logic [3:0]        msg_len,
    input  logic              pld_valid,
    input  logic [31:0]       pld_data,
    output logic              pld_ready,
    output logic [FLIT_W-1:0] odata,
    output logic              ovalid,
    output logic              ovch,
    input  logic [NVCH-1:0]   irdy
`ifdef NI_TX_STATS_EN
    ,
    output logic [15:0]       stat_pkts,
    output logic [15:0]       stat_flits,
    output logic [15:0]       stat_stall
`endif
);

    localparam logic [3:0] MAXLEN_L = 4'(MAXLEN);
    localparam logic [7:0] SRC_ID   = 8'(ROUTERID);

    state_t      state;
    logic [7:0]  dst_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt;
    logic        vc_q;
    logic        last_vc;

    logic        sel_grant;
    logic        sel_valid;
    logic        head_issue;
    logic        data_issue;
    logic        issue;
    logic        issue_vc;
    flit_type_t  ftype;
    logic [FLIT_W-1:0] flit;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l == 4'd0) return 4'd1;
        if (l > MAXLEN_L) return MAXLEN_L;
        return l;
    endfunction

    ni_vcsel u_vcsel (
        .irdy    (irdy[1:0]),
        .last_vc (last_vc),
        .grant   (sel_grant),
        .valid   (sel_valid)
    );

    assign msg_ready = (state == ST_IDLE) && !rst_;
    assign pld_ready = data_issue && !rst_;

    // The VC is picked in the same cycle the head issues, then held in vc_q
    always_comb begin
        head_issue = (state == ST_HEAD) && sel_valid;
        data_issue = (state == ST_DATA) && irdy[vc_q] && pld_valid;
        issue      = head_issue || data_issue;
        issue_vc   = head_issue ? sel_grant : vc_q;
        ftype      = FT_NONE;
        flit       = '0;
        if (head_issue) begin
            ftype       = (len_q == 4'd1) ? FT_HEADTAIL : FT_HEAD;
            flit[31:0]  = make_head(dst_q, SRC_ID, sel_grant, len_q);
        end else if (data_issue) begin
            ftype       = (cnt == 4'd1) ? FT_TAIL : FT_BODY;
            flit[31:0]  = pld_data;
        end
        flit[TYPE_MSB:TYPE_LSB] = ftype;
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state   <= ST_IDLE;
            dst_q   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            vc_q    <= 1'b0;
            last_vc <= 1'b1;
            odata   <= '0;
            ovalid  <= 1'b0;
            ovch    <= 1'b0;
        end else begin
            odata  <= flit;
            ovalid <= issue;
            if (issue) ovch <= issue_vc;
            case (state)
                ST_IDLE: begin
                    if (msg_valid) begin
                        dst_q <= msg_dst;
                        len_q <= clamp_len(msg_len);
                        cnt   <= clamp_len(msg_len);
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (head_issue) begin
                        vc_q    <= sel_grant;
                        last_vc <= sel_grant;
                        cnt     <= cnt - 4'd1;
                        state   <= (len_q == 4'd1) ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_issue) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NI_TX_STATS_EN
    // Stall cycles are those with a packet in flight but nothing issued
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
            stat_stall <= '0;
        end else begin
            stat_pkts  <= stat_pkts  + {15'd0, head_issue};
            stat_flits <= stat_flits + {15'd0, issue};
            stat_stall <= stat_stall + {15'd0, (state != ST_IDLE) && !issue};
        end
    end
`endif

endmodule

// File: tb/tb_ni_tx.sv
// Self-checking bench for ni_tx: expected flits are queued as stimulus is
// driven and compared by a monitor as the DUT emits them.
module tb_ni_tx;

    logic        clk;
    logic        rst_;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_dst;
    logic [3:0]  msg_len;
    logic        pld_valid;
    logic [31:0] pld_data;
    logic        pld_ready;
    logic [34:0] odata;
    logic        ovalid;
    logic        ovch;
    logic [1:0]  irdy;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    ni_tx #(.ROUTERID(8'h5A), .NVCH(2), .MAXLEN(8)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_dst   (msg_dst),
        .msg_len   (msg_len),
        .pld_valid (pld_valid),
        .pld_data  (pld_data),
        .pld_ready (pld_ready),
        .odata     (odata),
        .ovalid    (ovalid),
        .ovch      (ovch),
        .irdy      (irdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] exp_head(input logic vc, input logic [7:0] d, input logic [3:0] l);
        logic [2:0] t;
        t = (l == 4'd1) ? 3'd4 : 3'd1;
        return {vc, t, d, 8'h5A, vc, l, 11'd0};
    endfunction

    function automatic logic [35:0] exp_data(input logic vc, input logic last, input logic [31:0] w);
        return {vc, (last ? 3'd3 : 3'd2), w};
    endfunction

    // Scoreboard monitor: every valid flit must match the oldest expectation
    always @(negedge clk) begin
        logic [35:0] e;
        if (ovalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_flit: got vc=%0d flit=%h, required no flit", ovch, odata);
            end else begin
                e = exp_q.pop_front();
                if ({ovch, odata} !== e) begin
                    errors++;
                    $display("[TB] FAIL flit: got vc=%0d flit=%h, required vc=%0d flit=%h",
                             ovch, odata, e[35], e[34:0]);
                end
            end
        end else begin
            checks++;
            if (odata !== 35'd0) begin
                errors++;
                $display("[TB] FAIL odata_idle: got %h, required 0", odata);
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic wait_msg_ready();
        int n;
        n = 0;
        while (!msg_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!msg_ready) begin
            errors++;
            $display("[TB] FAIL msg_ready_timeout: got 0, required 1");
        end
    endtask

    task automatic send_packet(input logic [7:0] d, input logic [3:0] req_len,
                               input logic [3:0] eff_len, input logic vc);
        logic [31:0] w;
        int n;
        exp_q.push_back(exp_head(vc, d, eff_len));
        wait_msg_ready();
        msg_valid = 1'b1;
        msg_dst   = d;
        msg_len   = req_len;
        @(negedge clk);
        msg_valid = 1'b0;
        for (int i = 1; i < int'(eff_len); i++) begin
            w = $urandom;
            exp_q.push_back(exp_data(vc, i == int'(eff_len) - 1, w));
            pld_valid = 1'b1;
            pld_data  = w;
            #1;
            n = 0;
            while (!pld_ready && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (!pld_ready) begin
                errors++;
                $display("[TB] FAIL pld_ready_timeout: got 0, required 1");
            end
            @(negedge clk);
        end
        pld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        msg_valid = 1'b0; msg_dst = '0; msg_len = '0;
        pld_valid = 1'b1; pld_data = 32'hDEAD_BEEF;
        irdy = 2'b11;
        @(negedge clk);
        #1;
        checks++;
        if (msg_ready !== 1'b0 || pld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got msg_ready=%b pld_ready=%b, required 0 0", msg_ready, pld_ready);
        end
        checks++;
        if (ovalid !== 1'b0 || odata !== 35'd0 || ovch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ovalid=%b odata=%h ovch=%b, required 0 0 0", ovalid, odata, ovch);
        end
        @(negedge clk);
        rst_ = 1'b0;
        pld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_ready: got %b, required 1", msg_ready);
        end
    endtask

    task automatic test_headtail();
        irdy = 2'b11;
        exp_q.push_back(exp_head(1'b0, 8'h21, 4'd1));
        wait_msg_ready();
        msg_valid = 1'b1; msg_dst = 8'h21; msg_len = 4'd1;
        @(negedge clk);
        msg_valid = 1'b0;
        checks++;
        if (msg_ready !== 1'b0 || ovalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL headtail_c1: got msg_ready=%b ovalid=%b, required 0 0", msg_ready, ovalid);
        end
        @(negedge clk);
        checks++;
        if (msg_ready !== 1'b1 || ovalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL headtail_c2: got msg_ready=%b ovalid=%b, required 1 1", msg_ready, ovalid);
        end
        wait_drain();
    endtask

    task automatic test_long();
        logic [31:0] words[3];
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        irdy = 2'b01;
        exp_q.push_back(exp_head(1'b0, 8'h13, 4'd4));
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_data(1'b0, i == 2, words[i]));
        wait_msg_ready();
        msg_valid = 1'b1; msg_dst = 8'h13; msg_len = 4'd4;
        @(negedge clk);
        msg_valid = 1'b0; pld_valid = 1'b1; pld_data = words[0];
        #1;
        checks++;
        if (pld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_head_pld: got pld_ready=%b, required 0", pld_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) pld_data = words[i];
            else pld_valid = 1'b0;
            #1;
            checks++;
            if (ovalid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL long_consecutive: cycle %0d got ovalid=%b, required 1", i, ovalid);
            end
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        irdy = 2'b11;
        send_packet(8'h12, 4'd2, 4'd2, 1'b0);
        send_packet(8'h34, 4'd2, 4'd2, 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        a = 32'h1111_AAAA; b = 32'h2222_BBBB;
        irdy = 2'b01;
        exp_q.push_back(exp_head(1'b0, 8'h44, 4'd3));
        exp_q.push_back(exp_data(1'b0, 1'b0, a));
        exp_q.push_back(exp_data(1'b0, 1'b1, b));
        wait_msg_ready();
        msg_valid = 1'b1; msg_dst = 8'h44; msg_len = 4'd3;
        @(negedge clk);
        msg_valid = 1'b0; pld_valid = 1'b1; pld_data = a;
        @(posedge clk);
        #1 irdy = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pld_ready !== 1'b0 || (i > 0 && ovalid !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d got pld_ready=%b ovalid=%b, required 0 0", i, pld_ready, ovalid);
            end
        end
        @(negedge clk);
        checks++;
        if (ovalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_last: got ovalid=%b, required 0", ovalid);
        end
        irdy = 2'b01;
        #1;
        checks++;
        if (pld_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_resume: got pld_ready=%b, required 1", pld_ready);
        end
        @(negedge clk);
        pld_data = b;
        @(negedge clk);
        pld_valid = 1'b0;
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_idle: got msg_ready=%b, required 1", msg_ready);
        end
        wait_drain();
    endtask

    task automatic test_clamp();
        irdy = 2'b10;
        send_packet(8'h77, 4'd0, 4'd1, 1'b1);
        send_packet(8'h88, 4'd12, 4'd8, 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL clamp_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1, w2;
        w1 = 32'h5555_0001; w2 = 32'h5555_0002;
        irdy = 2'b01;
        exp_q.push_back(exp_head(1'b0, 8'h55, 4'd8));
        exp_q.push_back(exp_data(1'b0, 1'b0, w1));
        exp_q.push_back(exp_data(1'b0, 1'b0, w2));
        wait_msg_ready();
        msg_valid = 1'b1; msg_dst = 8'h55; msg_len = 4'd8;
        @(negedge clk);
        msg_valid = 1'b0; pld_valid = 1'b1; pld_data = w1;
        @(negedge clk);
        @(negedge clk);
        pld_data = w2;
        @(negedge clk);
        pld_data = 32'h5555_0003;
        #2 rst_ = 1'b1;
        #1;
        checks++;
        if (ovalid !== 1'b0 || odata !== 35'd0 || msg_ready !== 1'b0 || pld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset: got ovalid=%b odata=%h msg_ready=%b pld_ready=%b, required all 0",
                     ovalid, odata, msg_ready, pld_ready);
        end
        @(negedge clk);
        rst_ = 1'b0;
        pld_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_flits: got %0d pending, required 0", exp_q.size());
        end
        irdy = 2'b11;
        send_packet(8'h66, 4'd1, 4'd1, 1'b0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL after_reset_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_headtail();
        test_long();
        test_back_to_back();
        test_stall();
        test_clamp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
